// File: rtl/alu_seq_top_if.sv
// Operand/result handshake bundle for alu_seq_top.
// The master side issues operations and consumes results.
// The slave side is the ALU.
interface alu_seq_top_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   s;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] F;
    logic [N-1:0] Hi;
    logic         G;
    logic         E;
    logic         L;
    logic         Zero;
    logic         carryOut;
    logic         Overflow;

    modport master (
        output in_valid, A, B, s, out_ready,
        input  in_ready, out_valid, F, Hi, G, E, L, Zero, carryOut, Overflow
    );

    modport slave (
        input  in_valid, A, B, s, out_ready,
        output in_ready, out_valid, F, Hi, G, E, L, Zero, carryOut, Overflow
    );
endinterface

// File: rtl/alu_seq_top.sv
// N-bit signed ALU with registered results and valid/ready on both sides.
// Arithmetic, logic and shifter ops complete on the accept edge.
// Multiply and divide run N iterations of shift-add or restoring division
// on operand magnitudes. The sign is fixed up on the final edge.
module alu_seq_top #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_top_if.slave  bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t         state, state_nxt;
    logic           accept, start_mc, last_iter, load;
    logic [SW-1:0]  amt;

    // Latched multi-cycle operation
    logic [N-1:0]   op_a, op_b, mag_b, lo_reg;
    logic [N:0]     hi_reg;
    logic           op_signed, op_div;
    logic [SW-1:0]  cnt;
    logic [N-1:0]   a_mag, b_mag;

    // One iteration of the multi-cycle datapath
    logic [N:0]     mul_sum, div_shift, div_trial, hi_step;
    logic [N-1:0]   lo_step;

    // Final multi-cycle result
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem, mc_f, mc_hi;
    logic           mc_o;

    // Single-cycle result
    logic [N-1:0]   add_y, sc_f;
    logic           add_cin, sc_c, sc_o;
    logic [N:0]     sum;
    logic [2*N-1:0] rol_wide;

    // Value loaded into the result registers
    logic [N-1:0]   nxt_f, nxt_hi, cmp_a, cmp_b;
    logic           nxt_c, nxt_o;

    assign accept    = bus.in_valid & bus.in_ready;
    assign start_mc  = (bus.s[1:0] == 2'b10);
    assign last_iter = (state == CALC) && (cnt == '0);
    assign load      = last_iter | (accept & ~start_mc);
    assign amt       = bus.B[SW-1:0];

    // Signed ops iterate on magnitudes. The magnitude of MIN is exactly 2^(N-1).
    assign a_mag = (!bus.s[2] && bus.A[N-1]) ? -bus.A : bus.A;
    assign b_mag = (!bus.s[2] && bus.B[N-1]) ? -bus.B : bus.B;

    // FSM state register
    // NOTE: state elements use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state logic; an accepted op always wins over returning to IDLE
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = start_mc ? CALC : DONE;
            CALC: if (cnt == '0) state_nxt = DONE;
            DONE: begin
                if (accept)             state_nxt = start_mc ? CALC : DONE;
                else if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM handshake outputs
    always_comb begin
        bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
        bus.out_valid = (state == DONE);
    end

    // Single-cycle units: the shared adder, the logic ops and the shifter
    always_comb begin
        add_y   = bus.B;
        add_cin = 1'b0;
        case (bus.s[3:2])
            2'b00: begin add_y = bus.B;  add_cin = 1'b0; end
            2'b01: begin add_y = ~bus.B; add_cin = 1'b1; end
            2'b10: begin add_y = '0;     add_cin = 1'b1; end
            default: begin add_y = '1;   add_cin = 1'b0; end
        endcase
        sum      = {1'b0, bus.A} + {1'b0, add_y} + (N+1)'(add_cin);
        rol_wide = {bus.A, bus.A} << amt;
        sc_f = '0;
        sc_c = 1'b0;
        sc_o = 1'b0;
        case (bus.s[1:0])
            2'b00: begin
                sc_f = sum[N-1:0];
                sc_c = sum[N];
                sc_o = (bus.A[N-1] == add_y[N-1]) && (sum[N-1] != bus.A[N-1]);
            end
            2'b01: begin
                case (bus.s[3:2])
                    2'b00:   sc_f = bus.A & bus.B;
                    2'b01:   sc_f = bus.A | bus.B;
                    2'b10:   sc_f = bus.A ^ bus.B;
                    default: sc_f = ~bus.A;
                endcase
            end
            2'b11: begin
                case (bus.s[3:2])
                    2'b00:   sc_f = bus.A << amt;
                    2'b01:   sc_f = bus.A >> amt;
                    2'b10:   sc_f = $signed(bus.A) >>> amt;
                    default: sc_f = rol_wide[2*N-1:N];
                endcase
            end
            default: sc_f = '0;
        endcase
    end

    // One shift-add multiply step or one restoring-divide step
    always_comb begin
        mul_sum   = lo_reg[0] ? hi_reg + {1'b0, mag_b} : hi_reg;
        div_shift = {hi_reg[N-1:0], lo_reg[N-1]};
        div_trial = div_shift - {1'b0, mag_b};
        if (op_div) begin
            if (!div_trial[N]) begin
                hi_step = div_trial;
                lo_step = {lo_reg[N-2:0], 1'b1};
            end else begin
                hi_step = div_shift;
                lo_step = {lo_reg[N-2:0], 1'b0};
            end
        end else begin
            hi_step = {1'b0, mul_sum[N:1]};
            lo_step = {mul_sum[0], lo_reg[N-1:1]};
        end
    end

    // Sign fix-up and divide exceptions applied to the last iteration's output
    always_comb begin
        prod = {hi_step[N-1:0], lo_step};
        quo  = lo_step;
        rem  = hi_step[N-1:0];
        if (op_signed && (op_a[N-1] ^ op_b[N-1])) begin
            prod = -prod;
            quo  = -quo;
        end
        if (op_signed && op_a[N-1]) rem = -rem;
        mc_f  = prod[N-1:0];
        mc_hi = prod[2*N-1:N];
        mc_o  = 1'b0;
        if (op_div) begin
            if (op_b == '0) begin
                mc_f  = '1;
                mc_hi = op_a;
                mc_o  = 1'b1;
            end else if (op_signed && op_a == {1'b1, {(N-1){1'b0}}} && op_b == '1) begin
                mc_f  = quo;
                mc_hi = '0;
                mc_o  = 1'b1;
            end else begin
                mc_f  = quo;
                mc_hi = rem;
            end
        end
    end

    // Select the source of the result load: finishing iteration or accepted single-cycle op
    always_comb begin
        if (last_iter) begin
            nxt_f  = mc_f;
            nxt_hi = mc_hi;
            nxt_c  = 1'b0;
            nxt_o  = mc_o;
            cmp_a  = op_a;
            cmp_b  = op_b;
        end else begin
            nxt_f  = sc_f;
            nxt_hi = '0;
            nxt_c  = sc_c;
            nxt_o  = sc_o;
            cmp_a  = bus.A;
            cmp_b  = bus.B;
        end
    end

    // Latch multi-cycle operands at acceptance, then iterate while in CALC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a      <= '0;
            op_b      <= '0;
            mag_b     <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            op_signed <= 1'b0;
            op_div    <= 1'b0;
            cnt       <= '0;
        end else if (accept && start_mc) begin
            op_a      <= bus.A;
            op_b      <= bus.B;
            mag_b     <= b_mag;
            lo_reg    <= a_mag;
            hi_reg    <= '0;
            op_signed <= ~bus.s[2];
            op_div    <= bus.s[3];
            cnt       <= SW'(N-1);
        end else if (state == CALC) begin
            hi_reg    <= hi_step;
            lo_reg    <= lo_step;
            cnt       <= cnt - SW'(1);
        end
    end

    // Result and flag registers load together and hold until the next result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.F        <= '0;
            bus.Hi       <= '0;
            bus.G        <= 1'b0;
            bus.E        <= 1'b0;
            bus.L        <= 1'b0;
            bus.Zero     <= 1'b1;
            bus.carryOut <= 1'b0;
            bus.Overflow <= 1'b0;
        end else if (load) begin
            bus.F        <= nxt_f;
            bus.Hi       <= nxt_hi;
            bus.G        <= $signed(cmp_a) > $signed(cmp_b);
            bus.E        <= cmp_a == cmp_b;
            bus.L        <= $signed(cmp_a) < $signed(cmp_b);
            bus.Zero     <= nxt_f == '0;
            bus.carryOut <= nxt_c;
            bus.Overflow <= nxt_o;
        end
    end
endmodule

// File: tb/tb_alu_seq_top.sv
// Bench for alu_seq_top: directed scenarios followed by randomized traffic.
// Expected beats come from an arithmetic reference model and go into a queue.
// A monitor compares each presented beat against the head of that queue.
module tb_alu_seq_top;
    localparam int N  = 8;
    localparam int SW = $clog2(N);
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    localparam logic [3:0] ADD  = 4'b0000, SUB = 4'b0100, XOR = 4'b1001;
    localparam logic [3:0] MUL  = 4'b0010, DIV = 4'b1010, DIVU = 4'b1110;
    localparam logic [3:0] SLL  = 4'b0011, SRA = 4'b1011, ROL = 4'b1111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rand_ready = 1'b0, ready_force = 1'b0, rnd_ready = 1'b0;

    int checks = 0, failures = 0, beats = 0;
    logic [63:0] exp_q[$];

    alu_seq_top_if #(.N(N)) bus();
    alu_seq_top #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.out_ready = rand_ready ? rnd_ready : ready_force;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_out();
        return 64'({bus.F, bus.Hi, bus.G, bus.E, bus.L, bus.Zero, bus.carryOut, bus.Overflow});
    endfunction

    // Reference model: plain integer arithmetic on the operand values
    function automatic logic [63:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op);
        longint sa, sb, ua, ub, mask, max_s, min_s, r, full, p, f, hi;
        int amt;
        bit c, o;
        mask  = (longint'(1) << N) - 1;
        max_s = (longint'(1) << (N-1)) - 1;
        min_s = -(longint'(1) << (N-1));
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        amt = int'(b[SW-1:0]);
        f = 0; hi = 0; c = 0; o = 0; r = 0; full = 0;
        case (op[1:0])
            2'b00: begin
                case (op[3:2])
                    2'b00: begin full = ua + ub;                  r = sa + sb; end
                    2'b01: begin full = ua + ((~ub) & mask) + 1; r = sa - sb; end
                    2'b10: begin full = ua + 1;                   r = sa + 1;  end
                    default: begin full = ua + mask;              r = sa - 1;  end
                endcase
                f = full & mask;
                c = ((full >> N) & 1) != 0;
                o = (r > max_s) || (r < min_s);
            end
            2'b01: begin
                case (op[3:2])
                    2'b00:   f = ua & ub;
                    2'b01:   f = ua | ub;
                    2'b10:   f = ua ^ ub;
                    default: f = (~ua) & mask;
                endcase
            end
            2'b10: begin
                case (op[3:2])
                    2'b00, 2'b01: begin
                        p  = (op[3:2] == 2'b00) ? sa * sb : ua * ub;
                        f  = p & mask;
                        hi = (p >> N) & mask;
                    end
                    2'b10: begin
                        if (sb == 0) begin f = mask; hi = ua; o = 1; end
                        else if (sa == min_s && sb == -1) begin f = ua; hi = 0; o = 1; end
                        else begin f = (sa / sb) & mask; hi = (sa % sb) & mask; end
                    end
                    default: begin
                        if (ub == 0) begin f = mask; hi = ua; o = 1; end
                        else begin f = ua / ub; hi = ua % ub; end
                    end
                endcase
            end
            default: begin
                case (op[3:2])
                    2'b00:   f = (ua << amt) & mask;
                    2'b01:   f = ua >> amt;
                    2'b10:   f = (sa >>> amt) & mask;
                    default: f = ((ua << amt) | (ua >> (N - amt))) & mask;
                endcase
            end
        endcase
        return 64'({f[N-1:0], hi[N-1:0], sa > sb, sa == sb, sa < sb, f == 0, c, o});
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return MIN;
            1: return '1;
            2: return '0;
            3: return N'(1);
            default: return N'($urandom);
        endcase
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                        output int waits);
        bit done = 0;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.s = op;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1;
                exp_q.push_back(model(a, b, op));
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waits++;
                if (waits > 200) begin
                    check("send_timeout", 64'(waits), 64'(0));
                    done = 1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.A = N'($urandom);
        bus.B = N'($urandom);
        bus.s = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // Scoreboard monitor: every presented beat must match the oldest expected one
    always @(negedge clk) begin
        if (rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", dut_out(), 64'(0));
            end else begin
                check("beat", dut_out(), exp_q[0]);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int beats_before;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.s = '0;

        // Reset state
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_outputs", dut_out(), 64'h4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ready_force = 1'b1;

        // ADD overflow, accepted on the first edge after reset release
        send(N'(127), N'(1), ADD, w);
        check("add_first_edge", 64'(w), 64'(0));
        check("add_latency", 64'(bus.out_valid), 64'(1));
        check("add_F", 64'(bus.F), 64'h80);
        check("add_flags", 64'({bus.Overflow, bus.carryOut, bus.G, bus.E, bus.L, bus.Zero}),
              64'(6'b101000));

        // SUB to zero, then XOR back-to-back
        send(N'(5), N'(5), SUB, w);
        check("sub_flags", 64'({bus.Zero, bus.E, bus.carryOut}), 64'(3'b111));
        send(8'h0F, 8'hFF, XOR, w);
        check("b2b_wait", 64'(w), 64'(0));
        check("b2b_valid", 64'(bus.out_valid), 64'(1));
        check("xor_F", 64'(bus.F), 64'hF0);
        @(posedge clk);
        #1;

        // Signed multiply with stalled consumer
        ready_force = 1'b0;
        send(-N'(3), N'(7), MUL, w);
        for (int i = 0; i < N; i++) begin
            check("mul_busy", 64'({bus.in_ready, bus.out_valid}), 64'(0));
            @(posedge clk);
            #1;
        end
        check("mul_latency", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check("mul_hold", 64'({bus.out_valid, bus.Hi, bus.F}), 64'({1'b1, 16'hFFEB}));
            @(posedge clk);
            #1;
        end
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        check("mul_drop", 64'(bus.out_valid), 64'(0));

        // Division cases
        send(-N'(7), N'(2), DIV, w);
        send(N'(200), N'(0), DIVU, w);
        send(MIN, '1, DIV, w);
        drain();

        // Shifter cases
        send(8'h80, N'(3), SRA, w);
        send(8'h81, N'(1), ROL, w);
        send(8'h01, 8'h0B, SLL, w);
        drain();

        // Reset in the middle of a multiply
        send(-N'(3), N'(7), MUL, w);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'(1));
        check("abort_out_valid", 64'(bus.out_valid), 64'(0));
        check("abort_outputs", dut_out(), 64'h4);
        exp_q.delete();
        beats_before = beats;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (N + 4) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_beat", 64'(beats), 64'(beats_before));
        send(N'(1), N'(2), ADD, w);
        check("post_abort_latency", 64'(bus.out_valid), 64'(1));
        check("post_abort_F", 64'(bus.F), 64'(3));
        drain();

        // Randomized traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(pick(), pick(), 4'($urandom), w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
